regfile_read_ports: RTL and testbench
=====================================

REGFILE_READ_PORTS -- requirements
Module: regfile_read_ports

Interface
REQ-001 The block SHALL have parameter N, default 18: data width in bits.
REQ-002 The block SHALL have parameter AW, default 3: address width; depth is 2**AW entries.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port we  input  1  write enable.
REQ-006 The block SHALL have port waddr  input  AW  write address.
REQ-007 The block SHALL have port wdata  input  N  write data.
REQ-008 The block SHALL have port a_req  input  1  port A read request.
REQ-009 The block SHALL have port a_addr  input  AW  port A read address.
REQ-010 The block SHALL have port a_valid  output  1  port A data valid, high one cycle per request.
REQ-011 The block SHALL have port a_data  output  N  port A read data, registered.
REQ-012 The block SHALL have ports b_req, b_addr, b_valid and b_data, identical to port A, for independent read port B.

Function
REQ-013 The block SHALL hold 2**AW registers of N bits; when we=1 at a rising edge, entry waddr SHALL take wdata, and all other entries SHALL hold.
REQ-014 When a_req=1 at edge k, a_valid SHALL be 1 after edge k, and a_data SHALL equal the value of entry a_addr as it stands after edge k; read latency is one cycle.
REQ-015 When a_req=1, we=1 and waddr=a_addr in the same cycle, a_data SHALL return wdata (write-before-read bypass), never the stale entry.
REQ-016 When a_req=0 at an edge, a_valid SHALL be 0 after that edge, and a_data SHALL hold its previous value.
REQ-017 Back-to-back requests on consecutive cycles SHALL each produce one valid cycle, so a_valid stays high continuously with no bubble.
REQ-018 Ports A and B SHALL operate independently; simultaneous requests to the same address SHALL return identical data, including bypass.
REQ-019 The read path SHALL never modify storage, and valid SHALL depend only on the previous cycle's request.
REQ-020 All addresses 0..2**AW-1 SHALL be legal; no out-of-range case exists.

Reset
REQ-021 While reset_n=0, the block SHALL force all entries, a_data and b_data to 0, and a_valid and b_valid to 0, immediately and without waiting for clk.
REQ-022 Requests and writes presented while reset_n=0 SHALL be discarded.
REQ-023 A request in flight when reset asserts SHALL produce no valid pulse.
REQ-024 At the first rising edge after reset_n rises, the block SHALL accept requests and writes normally.

Configuration
REQ-025 The block SHALL support the macro REGFILE_R0_ZERO_EN.
REQ-026 When REGFILE_R0_ZERO_EN is defined, the block SHALL treat entry 0 as constant zero.
REQ-027 When REGFILE_R0_ZERO_EN is defined, the block SHALL ignore writes to address 0.
REQ-028 When REGFILE_R0_ZERO_EN is defined, reads of address 0 SHALL return 0, including when a same-cycle write targets address 0.
REQ-029 When REGFILE_R0_ZERO_EN is undefined, the block SHALL treat entry 0 as an ordinary register.

Verification
REQ-030 The bench SHALL cover basic write then read: write 0x2A5F3 to addr 5; next cycle a_req with addr 5 -> a_valid pulses 1 for one cycle with a_data=0x2A5F3.
REQ-031 The bench SHALL cover bypass: in the same cycle we=1, waddr=3, wdata=0x00ABC and a_req=1, a_addr=3 (entry 3 previously 0x11111) -> a_data=0x00ABC.
REQ-032 The bench SHALL cover dual port plus hold: a_req with addr 1 and b_req with addr 1 (entry 1=0x3FFFF) -> both data=0x3FFFF; then requests drop -> valids 0 and data held at 0x3FFFF.
REQ-033 The bench SHALL cover streaming: a_req high for 4 cycles with addrs 0,1,2,3 holding 10,20,30,40 -> a_valid high for 4 consecutive cycles with data 10,20,30,40.
REQ-034 The bench SHALL cover reset mid-operation: pull reset_n low between clock edges while a_req is pending -> a_valid and a_data go to 0 immediately, no valid pulse after release, and a read of the old address returns 0.
REQ-035 The bench SHALL cover R0: write 0x12345 to addr 0, then read addr 0 -> returns 0 with REGFILE_R0_ZERO_EN defined and 0x12345 without it.

Source files
------------

// File: rtl/regfile_read_ports.sv
// Register file with one write port and two independent registered read ports.
// Each read returns the entry as it stands after the request edge, so a
// same-cycle write to the read address is forwarded (write-before-read).
// Optional build macro REGFILE_R0_ZERO_EN: entry 0 reads as constant zero and
// writes to address 0 are dropped.
module regfile_read_ports #(
  parameter int N  = 18,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_valid,
  output logic [N-1:0]  a_data,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_valid,
  output logic [N-1:0]  b_data
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [N-1:0] mem [DEPTH];
  logic         wr_en;
  logic [N-1:0] a_next;
  logic [N-1:0] b_next;

  // Qualify the write strobe; with the zero-register option, address 0 is never written.
  always_comb begin
    wr_en = we;
`ifdef REGFILE_R0_ZERO_EN
    if (waddr == '0) wr_en = 1'b0;
`else
    wr_en = we;
`endif
  end

  // Read values with write forwarding. Entry 0 stays zero under the option
  // because wr_en is suppressed there, so no extra masking is needed.
  always_comb begin
    a_next = mem[a_addr];
    b_next = mem[b_addr];
    if (wr_en && (waddr == a_addr)) a_next = wdata;
    if (wr_en && (waddr == b_addr)) b_next = wdata;
  end

  // Storage array: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Port A output register: valid follows the request, data holds when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid <= 1'b0;
      a_data  <= '0;
    end else begin
      a_valid <= a_req;
      if (a_req) a_data <= a_next;
    end
  end

  // Port B output register: valid follows the request, data holds when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_valid <= 1'b0;
      b_data  <= '0;
    end else begin
      b_valid <= b_req;
      if (b_req) b_data <= b_next;
    end
  end

endmodule

// File: tb/tb_regfile_read_ports.sv
// Self-checking bench for regfile_read_ports: directed scenarios plus a
// randomized run, all compared against an array-based reference model.
module tb_regfile_read_ports;

  localparam int N  = 18;
  localparam int AW = 3;
  localparam int D  = 2 ** AW;
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [N-1:0]  wdata = '0;
  logic          a_req = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic          a_valid;
  logic [N-1:0]  a_data;
  logic          b_req = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic          b_valid;
  logic [N-1:0]  b_data;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [N-1:0] m_mem [D];
  logic         exp_a_valid, exp_b_valid;
  logic [N-1:0] exp_a_data, exp_b_data;

  regfile_read_ports #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .a_req(a_req), .a_addr(a_addr), .a_valid(a_valid), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_valid(b_valid), .b_data(b_data)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    exp_a_valid = 1'b0; exp_b_valid = 1'b0;
    exp_a_data = '0;    exp_b_data = '0;
  endtask

  // Advance one rising edge, update the model (write lands first, reads then
  // see the post-edge contents), and return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      if (we && !(R0 && waddr == 0)) m_mem[waddr] = wdata;
      exp_a_valid = a_req;
      exp_b_valid = b_req;
      if (a_req) exp_a_data = m_mem[a_addr];
      if (b_req) exp_b_data = m_mem[b_addr];
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic write_entry(input int addr, input logic [N-1:0] val);
    idle_inputs();
    we = 1'b1; waddr = AW'(addr); wdata = val;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    model_clear();
    #3;
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
    checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
    checks++; if (a_data !== '0) begin failures++; $display("FAIL reset_a_data got=%h exp=0", a_data); end
    checks++; if (b_data !== '0) begin failures++; $display("FAIL reset_b_data got=%h exp=0", b_data); end
    // Writes and requests during reset are discarded
    we = 1'b1; waddr = 3'd2; wdata = 18'h1F0F0; a_req = 1'b1; a_addr = 3'd2;
    step();
    step();
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_req_ignored got=%b exp=0", a_valid); end
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    // Every entry reads zero after reset
    for (int i = 0; i < D; i++) begin
      a_req = 1'b1; a_addr = AW'(i);
      step();
      checks++; if (a_data !== '0 || a_valid !== 1'b1) begin
        failures++; $display("FAIL reset_entry%0d got=%h/%b exp=0/1", i, a_data, a_valid);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_basic_write_read();
    write_entry(5, 18'h2A5F3);
    a_req = 1'b1; a_addr = 3'd5;
    step();
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", a_valid); end
    checks++; if (a_data !== 18'h2A5F3) begin failures++; $display("FAIL basic_data got=%h exp=2a5f3", a_data); end
    a_req = 1'b0;
    step();
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_end got=%b exp=0", a_valid); end
  endtask

  task automatic test_bypass();
    write_entry(3, 18'h11111);
    we = 1'b1; waddr = 3'd3; wdata = 18'h00ABC;
    a_req = 1'b1; a_addr = 3'd3; b_req = 1'b1; b_addr = 3'd3;
    step();
    checks++; if (a_data !== 18'h00ABC) begin failures++; $display("FAIL bypass_a got=%h exp=00abc", a_data); end
    checks++; if (b_data !== 18'h00ABC) begin failures++; $display("FAIL bypass_b got=%h exp=00abc", b_data); end
    idle_inputs();
    step();
  endtask

  task automatic test_dual_hold();
    write_entry(1, 18'h3FFFF);
    a_req = 1'b1; a_addr = 3'd1; b_req = 1'b1; b_addr = 3'd1;
    step();
    checks++; if (a_valid !== 1'b1 || a_data !== 18'h3FFFF) begin failures++; $display("FAIL dual_a got=%b/%h exp=1/3ffff", a_valid, a_data); end
    checks++; if (b_valid !== 1'b1 || b_data !== 18'h3FFFF) begin failures++; $display("FAIL dual_b got=%b/%h exp=1/3ffff", b_valid, b_data); end
    a_req = 1'b0; b_req = 1'b0; a_addr = 3'd5; b_addr = 3'd3;
    step();
    step();
    checks++; if (a_valid !== 1'b0 || a_data !== 18'h3FFFF) begin failures++; $display("FAIL hold_a got=%b/%h exp=0/3ffff", a_valid, a_data); end
    checks++; if (b_valid !== 1'b0 || b_data !== 18'h3FFFF) begin failures++; $display("FAIL hold_b got=%b/%h exp=0/3ffff", b_valid, b_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) write_entry(i, N'(10 * (i + 1)));
    for (int i = 0; i < 4; i++) begin
      a_req = 1'b1; a_addr = AW'(i);
      step();
      checks++; if (a_valid !== 1'b1 || a_data !== exp_a_data) begin
        failures++; $display("FAIL stream%0d got=%b/%0d exp=1/%0d", i, a_valid, a_data, exp_a_data);
      end
    end
    a_req = 1'b0;
    step();
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%b exp=0", a_valid); end
  endtask

  task automatic test_reset_mid();
    write_entry(5, 18'h2A5F3);
    a_req = 1'b1; a_addr = 3'd5;
    step();
    // Request pending for the next edge; assert reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (a_valid !== 1'b0 || a_data !== '0) begin failures++; $display("FAIL midreset_async got=%b/%h exp=0/0", a_valid, a_data); end
    model_clear();
    step();
    idle_inputs();
    #2;
    reset_n = 1'b1;
    step();
    checks++; if (a_valid !== 1'b0 || a_data !== '0) begin failures++; $display("FAIL midreset_nopulse got=%b/%h exp=0/0", a_valid, a_data); end
    a_req = 1'b1; a_addr = 3'd5;
    step();
    checks++; if (a_valid !== 1'b1 || a_data !== '0) begin failures++; $display("FAIL midreset_cleared got=%b/%h exp=1/0", a_valid, a_data); end
    idle_inputs();
    step();
  endtask

  task automatic test_r0();
    logic [N-1:0] want;
    want = R0 ? '0 : 18'h12345;
    write_entry(0, 18'h12345);
    a_req = 1'b1; a_addr = 3'd0;
    step();
    checks++; if (a_data !== want) begin failures++; $display("FAIL r0_read got=%h exp=%h", a_data, want); end
    // Same-cycle write to 0 with reads on both ports
    we = 1'b1; waddr = 3'd0; wdata = 18'h2BCDE; b_req = 1'b1; b_addr = 3'd0;
    want = R0 ? '0 : 18'h2BCDE;
    step();
    checks++; if (a_data !== want || b_data !== want) begin failures++; $display("FAIL r0_bypass got=%h/%h exp=%h", a_data, b_data, want); end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      we = 1'($urandom); waddr = AW'($urandom); wdata = N'($urandom);
      a_req = 1'($urandom); a_addr = AW'($urandom);
      b_req = 1'($urandom); b_addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
      step();
      checks++;
      if (a_valid !== exp_a_valid || a_data !== exp_a_data || b_valid !== exp_b_valid || b_data !== exp_b_data) begin
        failures++;
        $display("FAIL random%0d got=%b/%h %b/%h exp=%b/%h %b/%h", c, a_valid, a_data, b_valid, b_data,
                 exp_a_valid, exp_a_data, exp_b_valid, exp_b_data);
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_basic_write_read();
    test_bypass();
    test_dual_hold();
    test_back_to_back();
    test_reset_mid();
    test_r0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
